// File: rtl/axi_master_bfm.sv
// AXI4 master bridge: turns a command/data stream into AXI4 INCR bursts and returns R/B to the user side.
// Optional response-error counter is enabled by defining AXI_MASTER_BFM_RESP_CHECK_EN.
module axi_master_bfm #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 64,
   parameter int MASK_WIDTH = DATA_WIDTH/8,
   parameter int ID_WIDTH   = 4,
   parameter int MAX_OUTS   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   // command side
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   // user write data
   input  logic [DATA_WIDTH-1:0] usr_wdata,
   input  logic [MASK_WIDTH-1:0] usr_wstrb,
   input  logic                  usr_wvalid,
   output logic                  usr_wready,
   // user read data
   output logic [DATA_WIDTH-1:0] usr_rdata,
   output logic [ID_WIDTH-1:0]   usr_rid,
   output logic                  usr_rlast,
   output logic [1:0]            usr_rresp,
   output logic                  usr_rvalid,
   input  logic                  usr_rready,
   // user write response
   output logic [ID_WIDTH-1:0]   usr_bid,
   output logic [1:0]            usr_bresp,
   output logic                  usr_bvalid,
   input  logic                  usr_bready,
   output logic [15:0]           resp_err_cnt,
   // AXI write address
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic [3:0]            m_axi_awqos,
   output logic [3:0]            m_axi_awregion,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   // AXI write data
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [MASK_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   // AXI write response
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   // AXI read address
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic [3:0]            m_axi_arqos,
   output logic [3:0]            m_axi_arregion,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   // AXI read data
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   // state  | meaning
   // W_IDLE | no write burst open; a new write command may be taken
   // W_DATA | forwarding user beats to W until the beat with wlast

   localparam logic [2:0] AX_SIZE  = 3'($clog2(MASK_WIDTH));
   localparam logic [7:0] OUTS_MAX = 8'(MAX_OUTS);

   typedef enum logic [0:0] {W_IDLE, W_DATA} w_state_t;

   w_state_t   w_state, w_state_nxt;
   logic [7:0] beat_cnt;
   logic [7:0] rd_outs, wr_outs;
   logic       rd_acc, wr_acc, w_hs, r_done, b_done;

   assign rd_acc = cmd_valid & cmd_ready & ~cmd_wr;
   assign wr_acc = cmd_valid & cmd_ready &  cmd_wr;
   assign w_hs   = m_axi_wvalid & m_axi_wready;
   assign r_done = m_axi_rvalid & m_axi_rready & m_axi_rlast;
   assign b_done = m_axi_bvalid & m_axi_bready;

   // cmd_ready is held low during reset even though it is combinational
   always_comb begin
      cmd_ready = 1'b0;
      if (!rst) begin
         if (cmd_wr)
            cmd_ready = ~m_axi_awvalid & (w_state == W_IDLE) & (wr_outs < OUTS_MAX);
         else
            cmd_ready = ~m_axi_arvalid & (rd_outs < OUTS_MAX);
      end
   end

   assign m_axi_awsize   = AX_SIZE;
   assign m_axi_awburst  = 2'b01;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awcache  = 4'b0011;
   assign m_axi_awprot   = 3'b000;
   assign m_axi_awqos    = 4'b0000;
   assign m_axi_awregion = 4'b0000;
   assign m_axi_arsize   = AX_SIZE;
   assign m_axi_arburst  = 2'b01;
   assign m_axi_arlock   = 1'b0;
   assign m_axi_arcache  = 4'b0011;
   assign m_axi_arprot   = 3'b000;
   assign m_axi_arqos    = 4'b0000;
   assign m_axi_arregion = 4'b0000;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_axi_arvalid <= 1'b0;
         m_axi_arid    <= '0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= '0;
      end else if (rd_acc) begin
         m_axi_arvalid <= 1'b1;
         m_axi_arid    <= cmd_id;
         m_axi_araddr  <= cmd_addr;
         m_axi_arlen   <= cmd_len;
      end else if (m_axi_arready) begin
         m_axi_arvalid <= 1'b0;
      end
   end

   // awlen doubles as the burst length for wlast; it cannot change while W_DATA is open
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axi_awvalid <= 1'b0;
         m_axi_awid    <= '0;
         m_axi_awaddr  <= '0;
         m_axi_awlen   <= '0;
      end else if (wr_acc) begin
         m_axi_awvalid <= 1'b1;
         m_axi_awid    <= cmd_id;
         m_axi_awaddr  <= cmd_addr;
         m_axi_awlen   <= cmd_len;
      end else if (m_axi_awready) begin
         m_axi_awvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_outs <= '0;
         wr_outs <= '0;
      end else begin
         case ({rd_acc, r_done})
            2'b10:   rd_outs <= rd_outs + 8'd1;
            2'b01:   rd_outs <= rd_outs - 8'd1;
            default: rd_outs <= rd_outs;
         endcase
         case ({wr_acc, b_done})
            2'b10:   wr_outs <= wr_outs + 8'd1;
            2'b01:   wr_outs <= wr_outs - 8'd1;
            default: wr_outs <= wr_outs;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state  <= W_IDLE;
         beat_cnt <= '0;
      end else begin
         w_state <= w_state_nxt;
         if (wr_acc)
            beat_cnt <= '0;
         else if (w_hs)
            beat_cnt <= beat_cnt + 8'd1;
      end
   end

   always_comb begin
      w_state_nxt  = w_state;
      m_axi_wvalid = 1'b0;
      m_axi_wlast  = 1'b0;
      usr_wready   = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (wr_acc)
               w_state_nxt = W_DATA;
         end
         W_DATA: begin
            m_axi_wvalid = usr_wvalid;
            usr_wready   = m_axi_wready;
            m_axi_wlast  = (beat_cnt == m_axi_awlen);
            if (usr_wvalid && m_axi_wready && (beat_cnt == m_axi_awlen))
               w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   assign m_axi_wdata = usr_wdata;
   assign m_axi_wstrb = usr_wstrb;

   assign usr_rdata    = m_axi_rdata;
   assign usr_rid      = m_axi_rid;
   assign usr_rlast    = m_axi_rlast;
   assign usr_rresp    = m_axi_rresp;
   assign usr_rvalid   = m_axi_rvalid;
   assign m_axi_rready = usr_rready;

   assign usr_bid      = m_axi_bid;
   assign usr_bresp    = m_axi_bresp;
   assign usr_bvalid   = m_axi_bvalid;
   assign m_axi_bready = usr_bready;

`ifdef AXI_MASTER_BFM_RESP_CHECK_EN
   logic        r_err, b_err;
   logic [15:0] err_inc;

   assign r_err   = m_axi_rvalid & m_axi_rready & (m_axi_rresp != 2'b00);
   assign b_err   = m_axi_bvalid & m_axi_bready & (m_axi_bresp != 2'b00);
   assign err_inc = 16'(r_err) + 16'(b_err);

   always_ff @(posedge clk) begin
      if (rst)
         resp_err_cnt <= '0;
      else if (resp_err_cnt > (16'hFFFF - err_inc))
         resp_err_cnt <= 16'hFFFF;
      else
         resp_err_cnt <= resp_err_cnt + err_inc;
   end
`else
   assign resp_err_cnt = 16'h0000;
`endif

endmodule
